// File: rtl/edge_bank_router.sv
// edge_bank_router: takes up to 8 edges per cycle from the conflict resolver.
// Each edge is steered to one of 8 show-ahead bank FIFOs, selected by its
// destination-bank field. The block also keeps sticky error flags and an
// accepted-edge counter for the scheduler.
module edge_bank_router #(
    parameter int EDGE_W       = 96,
    parameter int Bank_Num_W   = 3,
    parameter int FIFO_DEPTH_W = 2,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EDGE_W*8-1:0]   in_data,
    input  logic [7:0]            in_valid,
    input  logic                  stats_clr,
    output logic [EDGE_W*8-1:0]   bank_data,
    output logic [7:0]            bank_valid,
    input  logic [7:0]            bank_ready,
    output logic                  afull,
    output logic                  collision,
    output logic                  overflow,
    output logic [31:0]           edge_count
);

    localparam int NB    = 8;
    localparam int DEPTH = 1 << FIFO_DEPTH_W;
    localparam int CNT_W = FIFO_DEPTH_W + 1;

    // Stage 1 registers: lane payloads, lane valids and the one-hot bank decode.
    logic [NB-1:0][EDGE_W-1:0] r_s1_data;
    logic [NB-1:0]             r_s1_valid;
    logic [NB-1:0][NB-1:0]     r_s1_dec;
    logic [NB-1:0][NB-1:0]     w_dec;

    // Stage 2 bank-side write requests and the winning lane's payload.
    logic [NB-1:0]             w_wr_req;
    logic [NB-1:0][EDGE_W-1:0] w_wr_data;
    logic                      w_coll_evt;

    // FIFO state.
    logic [EDGE_W-1:0]             r_mem [NB][DEPTH];
    logic [NB-1:0][FIFO_DEPTH_W-1:0] r_wr_ptr;
    logic [NB-1:0][FIFO_DEPTH_W-1:0] r_rd_ptr;
    logic [NB-1:0][CNT_W-1:0]        r_count;
    logic [NB-1:0]                   w_pop;
    logic [NB-1:0]                   w_full;
    logic [NB-1:0]                   w_acc;
    logic [NB-1:0]                   w_drop;
    logic [3:0]                      w_acc_cnt;

    // Statistics registers.
    logic [31:0] r_edge_count;
    logic        r_collision;
    logic        r_overflow;

    // Decode each valid lane's destination bank into a one-hot row.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_dec = '0;
        for (int i = 0; i < NB; i++) begin
            if (in_valid[i]) begin
                w_dec[i][in_data[EDGE_W*i+32 +: Bank_Num_W]] = 1'b1;
            end
        end
    end

    // Stage 1 control: valids and decode are reset so a flushed pipeline stays empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_s1_valid <= '0;
            r_s1_dec   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_dec   <= w_dec;
        end
    end

    // Stage 1 payload: qualified by the decode, so it needs no reset.
    always_ff @(posedge clk) begin
        r_s1_data <= in_data;
    end

    // Per bank: the lowest-index hitting lane wins; any further hit is a collision.
    always_comb begin
        w_wr_req   = '0;
        w_wr_data  = '0;
        w_coll_evt = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < NB; i++) begin
                if (r_s1_valid[i] && r_s1_dec[i][b]) begin
                    if (w_wr_req[b]) begin
                        w_coll_evt = 1'b1;
                    end else begin
                        w_wr_req[b]  = 1'b1;
                        w_wr_data[b] = r_s1_data[i];
                    end
                end
            end
        end
    end

    // FIFO handshake: a full FIFO accepts a write only when it pops in the same cycle.
    always_comb begin
        w_pop     = '0;
        w_full    = '0;
        w_acc     = '0;
        w_drop    = '0;
        w_acc_cnt = '0;
        for (int b = 0; b < NB; b++) begin
            w_pop[b]  = (r_count[b] != '0) && bank_ready[b];
            w_full[b] = (r_count[b] == CNT_W'(DEPTH));
            w_acc[b]  = w_wr_req[b] && (!w_full[b] || w_pop[b]);
            w_drop[b] = w_wr_req[b] && w_full[b] && !w_pop[b];
            w_acc_cnt = w_acc_cnt + 4'(w_acc[b]);
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_acc[b]) r_wr_ptr[b] <= r_wr_ptr[b] + 1'b1;
                if (w_pop[b]) r_rd_ptr[b] <= r_rd_ptr[b] + 1'b1;
                r_count[b] <= r_count[b] + CNT_W'(w_acc[b]) - CNT_W'(w_pop[b]);
            end
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the counts mark every entry invalid and the output is masked when empty.
        for (int b = 0; b < NB; b++) begin
            if (w_acc[b]) r_mem[b][r_wr_ptr[b]] <= w_wr_data[b];
        end
    end

    // Sticky flags and the accepted-edge counter; a clear overrides same-cycle events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_count <= '0;
            r_collision  <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (stats_clr) begin
            r_edge_count <= '0;
            r_collision  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_edge_count <= r_edge_count + 32'(w_acc_cnt);
            r_collision  <= r_collision | w_coll_evt;
            r_overflow   <= r_overflow | (|w_drop);
        end
    end

    // Show-ahead outputs and the almost-full hint, both from the registered counts.
    always_comb begin
        bank_valid = '0;
        bank_data  = '0;
        afull      = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bank_valid[b] = (r_count[b] != '0);
            if (bank_valid[b]) bank_data[EDGE_W*b +: EDGE_W] = r_mem[b][r_rd_ptr[b]];
            if (r_count[b] >= CNT_W'(DEPTH - AFULL_MARGIN)) afull = 1'b1;
        end
    end

    assign collision  = r_collision;
    assign overflow   = r_overflow;
    assign edge_count = r_edge_count;

endmodule

// File: tb/tb_edge_bank_router.sv
// Bench for edge_bank_router. It drives directed steps, then a random
// conflict-free stream. Per-bank expected edges queue up when driven and
// are compared whenever a bank handshake completes.
module tb_edge_bank_router;

    localparam int EDGE_W = 96;
    localparam int NB     = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [EDGE_W*8-1:0] in_data;
    logic [7:0]          in_valid;
    logic                stats_clr;
    logic [EDGE_W*8-1:0] bank_data;
    logic [7:0]          bank_valid;
    logic [7:0]          bank_ready;
    logic                afull;
    logic                collision;
    logic                overflow;
    logic [31:0]         edge_count;

    logic [EDGE_W-1:0] sbq [NB][$];
    int errors = 0;
    int checks = 0;

    edge_bank_router dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .stats_clr  (stats_clr),
        .bank_data  (bank_data),
        .bank_valid (bank_valid),
        .bank_ready (bank_ready),
        .afull      (afull),
        .collision  (collision),
        .overflow   (overflow),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every handshake completing at the next rising edge, then advance one cycle.
    task automatic step();
        logic [EDGE_W-1:0] exp_e;
        for (int b = 0; b < NB; b++) begin
            if (bank_valid[b] && bank_ready[b]) begin
                check($sformatf("bank%0d_expected_pending", b), 96'(sbq[b].size() != 0), 96'd1);
                if (sbq[b].size() != 0) begin
                    exp_e = sbq[b].pop_front();
                    check($sformatf("bank%0d_data", b), bank_data[EDGE_W*b +: EDGE_W], exp_e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_lane(input int lane, input int bank, output logic [EDGE_W-1:0] e);
        e = {$urandom, $urandom, $urandom};
        e[34:32] = 3'(bank);
        in_data[EDGE_W*lane +: EDGE_W] = e;
        in_valid[lane] = 1'b1;
    endtask

    task automatic clear_stats();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
    endtask

    initial begin
        logic [EDGE_W-1:0] e;
        logic [EDGE_W-1:0] lane0_e;
        logic [31:0]       total;
        logic [7:0]        v;
        int                perm [NB];
        int                j;
        int                tmp;

        rst        = 1'b1;
        in_data    = '0;
        in_valid   = '0;
        stats_clr  = 1'b0;
        bank_ready = '0;
        #1 rst = 1'b0;
        #3;
        check("reset_bank_valid", 96'(bank_valid), 96'h0);
        check("reset_bank_data", bank_data[EDGE_W-1:0], 96'h0);
        check("reset_afull", 96'(afull), 96'h0);
        check("reset_collision", 96'(collision), 96'h0);
        check("reset_overflow", 96'(overflow), 96'h0);
        check("reset_edge_count", 96'(edge_count), 96'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();

        // All lanes, reversed banks: lane i goes to bank 7-i.
        bank_ready = 8'hFF;
        for (int i = 0; i < NB; i++) begin
            drive_lane(i, 7 - i, e);
            sbq[7 - i].push_back(e);
            if (i == 0) lane0_e = e;
        end
        step();
        in_valid = '0;
        check("fan_valid_after_1", 96'(bank_valid), 96'h0);
        step();
        check("fan_valid_after_2", 96'(bank_valid), 96'hFF);
        check("fan_bank7_lane0", bank_data[EDGE_W*7 +: EDGE_W], lane0_e);
        check("fan_edge_count", 96'(edge_count), 96'd8);
        check("fan_collision", 96'(collision), 96'h0);
        step();
        check("fan_valid_one_wide", 96'(bank_valid), 96'h0);

        // Collision: lanes 2 and 5 both target bank 3; lane 2 wins.
        clear_stats();
        check("clr_edge_count", 96'(edge_count), 96'd0);
        drive_lane(2, 3, e);
        sbq[3].push_back(e);
        drive_lane(5, 3, e);
        step();
        in_valid = '0;
        step();
        check("coll_bank_valid", 96'(bank_valid), 96'h08);
        check("coll_flag", 96'(collision), 96'h1);
        check("coll_edge_count", 96'(edge_count), 96'd1);
        step();
        step();
        check("coll_sticky", 96'(collision), 96'h1);
        check("coll_drained", 96'(bank_valid), 96'h0);
        clear_stats();
        check("coll_clr_flag", 96'(collision), 96'h0);
        check("coll_clr_count", 96'(edge_count), 96'd0);

        // Overflow: bank 0 stalled, six single-edge groups into a depth-4 FIFO.
        bank_ready = 8'hFE;
        for (int k = 0; k < 6; k++) begin
            in_valid = '0;
            drive_lane(k, 0, e);
            if (k < 4) sbq[0].push_back(e);
            step();
            j = k + 1;
            check($sformatf("ovf_afull_step%0d", j), 96'(afull), 96'(j >= 3));
            check($sformatf("ovf_flag_step%0d", j), 96'(overflow), 96'(j >= 6));
        end
        in_valid = '0;
        step();
        step();
        check("ovf_flag", 96'(overflow), 96'h1);
        check("ovf_edge_count", 96'(edge_count), 96'd4);
        check("ovf_bank_valid", 96'(bank_valid), 96'h01);
        bank_ready = 8'hFF;
        for (int k = 0; k < 4; k++) step();
        check("ovf_drained", 96'(bank_valid), 96'h0);
        check("ovf_afull_clear", 96'(afull), 96'h0);
        clear_stats();

        // Full FIFO 1 with a pop in the same cycle as a new write.
        bank_ready = 8'hFD;
        for (int k = 0; k < 5; k++) begin
            in_valid = '0;
            drive_lane(k, 1, e);
            sbq[1].push_back(e);
            step();
        end
        in_valid = '0;
        check("fullpop_afull", 96'(afull), 96'h1);
        bank_ready = 8'hFF;
        step();
        bank_ready = 8'hFD;
        check("fullpop_overflow", 96'(overflow), 96'h0);
        check("fullpop_edge_count", 96'(edge_count), 96'd5);
        bank_ready = 8'hFF;
        for (int k = 0; k < 3; k++) step();
        check("fullpop_count4_valid", 96'(bank_valid), 96'h02);
        step();
        check("fullpop_drained", 96'(bank_valid), 96'h0);
        clear_stats();

        // Random conflict-free stream, throttled on afull, with random ready.
        total = '0;
        for (int c = 0; c < 10000; c++) begin
            bank_ready = 8'($urandom);
            in_valid = '0;
            if (!afull) begin
                for (int i = 0; i < NB; i++) perm[i] = i;
                for (int i = NB - 1; i > 0; i--) begin
                    j = int'($urandom_range(i, 0));
                    tmp = perm[i];
                    perm[i] = perm[j];
                    perm[j] = tmp;
                end
                v = 8'($urandom);
                for (int i = 0; i < NB; i++) begin
                    if (v[i]) begin
                        drive_lane(i, perm[i], e);
                        sbq[perm[i]].push_back(e);
                        total = total + 32'd1;
                    end
                end
            end
            step();
        end
        in_valid = '0;
        bank_ready = 8'hFF;
        for (int k = 0; k < 8; k++) step();
        check("rand_edge_count", 96'(edge_count), 96'(total));
        check("rand_overflow", 96'(overflow), 96'h0);
        check("rand_collision", 96'(collision), 96'h0);
        check("rand_drained", 96'(bank_valid), 96'h0);
        for (int b = 0; b < NB; b++) check($sformatf("rand_sb_empty%0d", b), 96'(sbq[b].size()), 96'd0);

        // Asynchronous reset while FIFOs hold edges and stage 1 holds another group.
        bank_ready = 8'h00;
        for (int i = 0; i < NB; i++) drive_lane(i, 7 - i, e);
        step();
        in_valid = '0;
        step();
        check("rstmid_loaded", 96'(bank_valid), 96'hFF);
        for (int i = 0; i < NB; i++) drive_lane(i, i, e);
        step();
        in_valid = '0;
        #2 rst = 1'b0;
        #1;
        check("rstmid_bank_valid", 96'(bank_valid), 96'h0);
        check("rstmid_bank_data", bank_data[EDGE_W*3 +: EDGE_W], 96'h0);
        check("rstmid_edge_count", 96'(edge_count), 96'd0);
        check("rstmid_afull", 96'(afull), 96'h0);
        check("rstmid_collision", 96'(collision), 96'h0);
        check("rstmid_overflow", 96'(overflow), 96'h0);
        @(negedge clk);
        rst = 1'b1;
        bank_ready = 8'hFF;
        for (int k = 0; k < 3; k++) step();
        check("rstmid_nothing_after", 96'(bank_valid), 96'h0);
        check("rstmid_count_after", 96'(edge_count), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_bank_router.md
# edge_bank_router

Sits directly downstream of the 8-lane bank conflict resolver and consumes its eight registered lane outputs (`output_dataN`/`output_validN`). Each valid lane carries one edge, which the block steers to one of 8 bank queues selected by the edge's destination-bank field. Each per-bank FIFO presents edges to its bank update unit under a valid/ready handshake. The block also provides a backpressure hint, sticky error flags and an edge counter for the scheduler.

## Interface
- `EDGE_W`, 96: edge width in bits; bits [31:0] are the source field and bits [63:32] are the destination field.
- `Bank_Num_W`, 3: bank index width; fixed at 3 (8 banks, 8 lanes).
- `FIFO_DEPTH_W`, 2: log2 of per-bank FIFO depth (default depth 4).
- `AFULL_MARGIN`, 2: almost-full threshold is DEPTH − AFULL_MARGIN.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  EDGE_W*8  lane i at [EDGE_W*(i+1)-1 : EDGE_W*i].
- `in_valid`  in  8  per-lane valid, bit i ↔ lane i.
- `stats_clr`  in  1  synchronous clear of `edge_count`, `collision`, `overflow`.
- `bank_data`  out  EDGE_W*8  head of FIFO b at [EDGE_W*(b+1)-1 : EDGE_W*b].
- `bank_valid`  out  8  FIFO b non-empty.
- `bank_ready`  in  8  bank b accepts its head this cycle.
- `afull`  out  1  any FIFO count ≥ DEPTH − AFULL_MARGIN.
- `collision`  out  1  sticky: two valid lanes targeted one bank in the same cycle.
- `overflow`  out  1  sticky: write attempted into a full FIFO with no simultaneous pop.
- `edge_count`  out  32  total edges written into FIFOs, wraps modulo 2^32.

## Operation
- Destination bank of lane i: `in_data[EDGE_W*i+32+Bank_Num_W-1 : EDGE_W*i+32]`.
- Stage 1 (S1): register `in_data`, `in_valid`, and a per-lane one-hot bank decode (8×8 matrix, zero for invalid lanes).
- Stage 2 (S2) per bank b: write request = OR over lanes of decode[i][b]. Selected lane = lowest i with decode[i][b]=1. Higher-index lanes hitting b are dropped and `collision` is set.
- FIFO b: show-ahead. `bank_valid[b]` = count≠0; `bank_data` slice = head entry. Pop when `bank_valid[b] && bank_ready[b]`.
- Write to a full FIFO:
  - with a pop in the same cycle: accepted, count unchanged.
  - without a pop: edge dropped, `overflow` set, count unchanged.
- Write to an empty FIFO: never bypasses the FIFO; data appears the following cycle.
- `edge_count` += number of banks whose write was accepted this cycle (0..8). Dropped edges do not count.
- `stats_clr`:
  - zeroes `edge_count`, `collision` and `overflow` on the next edge.
  - If a collision, overflow or increment happens in the same cycle, the clear wins; that event is lost.
- `afull` is combinational from the registered counts.
- FIFO pointers are FIFO_DEPTH_W bits, wrapping naturally. Count is FIFO_DEPTH_W+1 bits so a full FIFO is distinguishable from an empty one.

## Timing
- Reset (`rst`=0, async): pipeline valids 0, all FIFOs empty, `bank_valid`=0, `bank_data`=0, `afull`=0, `collision`=0, `overflow`=0, `edge_count`=0.
- Reset asserted mid-operation flushes all in-flight and queued edges; nothing is output after release until new input arrives.
- Latency: lane valid at edge t → S1 at t+1 → FIFO write at t+2. `bank_valid` is visible after edge t+2 (2 cycles) when the FIFO was empty.
- Throughput: up to 8 edges/cycle in, 1 edge per bank per cycle out.
- There is no input backpressure. Upstream must throttle on `afull`. With AFULL_MARGIN=2 this covers the 2 cycles of in-flight data for a single target bank.
- `in_valid`=0 cycles are bubbles: there is no state change except pops.

## Test plan
- Reset release, then lanes 0..7 valid with destination banks 7,6,5,4,3,2,1,0, `bank_ready`=FF:
  - all 8 `bank_valid` high exactly 2 cycles later, one cycle wide.
  - bank 7 carries lane 0's edge.
  - `edge_count`=8; `collision`=0.
- Lanes 2 and 5 both valid with destination bank 3:
  - only lane 2's edge reaches bank 3.
  - `collision`=1 and stays high.
  - `edge_count`=1.
  - after `stats_clr`, `collision`=0 and `edge_count`=0.
- `bank_ready[0]`=0, six consecutive single-edge groups to bank 0 (depth 4):
  - `afull` rises when count reaches 2.
  - edges 5 and 6 are dropped; `overflow`=1; `edge_count`=4.
  - raising ready then drains edges 1..4 in order.
- FIFO 1 full with `bank_ready[1]`=1 and a new write to bank 1 in the same cycle: write accepted, count stays 4, `overflow`=0.
- Sustained random conflict-free groups for 10k cycles with random `bank_ready`: per-bank output order matches input order, and `edge_count` equals the scoreboard total modulo 2^32.
- Reset asserted while FIFOs hold edges: all `bank_valid` drop immediately, independent of clock; all flags and counters read 0.
